// File: rtl/reg_file_cfg_if.sv
// Request/response bundle for the configuration register file.
// Latency: n/a (wiring only). Backpressure: none, requests are single-cycle qualified.
// Ports: master drives WrEn/RdEn/Address/WrData; slave returns RdData/RdData_VLD/Acc_ERR/REG_TAPS.
interface reg_file_cfg_if #(
    parameter int WIDTH    = 8,
    parameter int ADDR     = 4,
    parameter int NUM_TAPS = 4
);
    logic                      WrEn;
    logic                      RdEn;
    logic [ADDR-1:0]           Address;
    logic [WIDTH-1:0]          WrData;
    logic [WIDTH-1:0]          RdData;
    logic                      RdData_VLD;
    logic                      Acc_ERR;
    logic [NUM_TAPS*WIDTH-1:0] REG_TAPS;

    modport master (
        output WrEn, RdEn, Address, WrData,
        input  RdData, RdData_VLD, Acc_ERR, REG_TAPS
    );

    modport slave (
        input  WrEn, RdEn, Address, WrData,
        output RdData, RdData_VLD, Acc_ERR, REG_TAPS
    );
endinterface

// File: rtl/reg_file_cfg.sv
// Configuration register file: DEPTH x WIDTH words, per-word reset image and write protection.
// Latency: write lands at the request edge; read data RD_LAT (1 or 2) cycles; Acc_ERR 1 cycle.
// Backpressure: none; one read and one write may be accepted every cycle.
// Ports: CLK, RST (sync, active-low), bus (slave side of reg_file_cfg_if).
module reg_file_cfg #(
    parameter int                     WIDTH    = 8,
    parameter int                     DEPTH    = 16,
    parameter int                     ADDR     = 4,
    parameter int                     NUM_TAPS = 4,
    parameter int                     RD_LAT   = 1,
    parameter logic [DEPTH*WIDTH-1:0] INIT_VEC = {{(DEPTH-4){WIDTH'(0)}}, WIDTH'(8'h20),
                                                  WIDTH'(8'h81), {2{WIDTH'(0)}}},
    parameter logic [DEPTH-1:0]       RO_MASK  = '0
) (
    input  logic          CLK,
    input  logic          RST,
    reg_file_cfg_if.slave bus
);
    localparam int unsigned DEPTH_U = DEPTH;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [WIDTH-1:0]          mem_d [DEPTH];
    logic                      err_q, err_d;
    logic                      vld1_q, vld1_d;
    logic [WIDTH-1:0]          dat1_q, dat1_d;
    logic                      in_range;
    logic                      ro_hit;
    logic                      wr_ok;
    logic [WIDTH-1:0]          rd_word;
    logic [NUM_TAPS*WIDTH-1:0] taps;

    // Address decode is done by scanning the implemented words so that an
    // out-of-range address never indexes past the array or the mask.
    always_comb begin
        in_range = (32'(bus.Address) < DEPTH_U);
        rd_word  = '0;
        ro_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.Address == ADDR'(i)) begin
                rd_word = mem_q[i];
                ro_hit  = RO_MASK[i];
            end
        end
        wr_ok = bus.WrEn & in_range & ~ro_hit;

        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && bus.Address == ADDR'(i)) begin
                mem_d[i] = bus.WrData;
            end
        end

        // Read and write faults merge into one pulse.
        err_d  = (bus.WrEn & ~wr_ok) | (bus.RdEn & ~in_range);
        vld1_d = bus.RdEn;
        // rd_word is the pre-write value, giving read-before-write on a collision.
        dat1_d = dat1_q;
        if (bus.RdEn) begin
            dat1_d = in_range ? rd_word : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VEC[i*WIDTH +: WIDTH];
            end
            err_q  <= 1'b0;
            vld1_q <= 1'b0;
            dat1_q <= '0;
        end else begin
            mem_q  <= mem_d;
            err_q  <= err_d;
            vld1_q <= vld1_d;
            dat1_q <= dat1_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             vld2_q;
            logic [WIDTH-1:0] dat2_q;

            // Extra stage; reset drops anything still in flight.
            always_ff @(posedge CLK) begin
                if (!RST) begin
                    vld2_q <= 1'b0;
                    dat2_q <= '0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) begin
                        dat2_q <= dat1_q;
                    end
                end
            end

            assign bus.RdData     = dat2_q;
            assign bus.RdData_VLD = vld2_q;
        end else begin : g_lat1
            assign bus.RdData     = dat1_q;
            assign bus.RdData_VLD = vld1_q;
        end
    endgenerate

    always_comb begin
        taps = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            taps[t*WIDTH +: WIDTH] = mem_q[t];
        end
    end

    assign bus.REG_TAPS = taps;
    assign bus.Acc_ERR  = err_q;
endmodule

// File: tb/tb_reg_file_cfg.sv
// Bench for reg_file_cfg: two instances (A: DEPTH16/RD_LAT1/word3 RO, B: DEPTH12/RD_LAT2/word4 RO).
// Latency: n/a. Backpressure: n/a.
// Directed steps then random traffic, compared each cycle against an abstract reference model.
module tb_reg_file_cfg;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    reg_file_cfg_if #(.WIDTH(8), .ADDR(4), .NUM_TAPS(4)) ifa ();
    reg_file_cfg_if #(.WIDTH(8), .ADDR(4), .NUM_TAPS(4)) ifb ();

    reg_file_cfg #(
        .WIDTH(8), .DEPTH(16), .ADDR(4), .NUM_TAPS(4), .RD_LAT(1),
        .INIT_VEC(128'h2081_0000), .RO_MASK(16'h0008)
    ) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));

    reg_file_cfg #(
        .WIDTH(8), .DEPTH(12), .ADDR(4), .NUM_TAPS(4), .RD_LAT(2),
        .INIT_VEC(96'h2081_0000), .RO_MASK(12'h010)
    ) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int         depth [2] = '{16, 12};
    int         lat   [2] = '{1, 2};
    logic [15:0] ro   [2] = '{16'h0008, 16'h0010};
    logic [7:0] m     [2][16];
    // Expected outputs keyed by the edge number after which they are visible.
    bit         sv    [2][2048];
    logic [7:0] sd    [2][2048];
    bit         se    [2][2048];
    logic [7:0] last  [2];
    int         e = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m[d][i] = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
            for (int k = 0; k < 3; k++) begin
                sv[d][e+k] = 1'b0;
                se[d][e+k] = 1'b0;
            end
            last[d] = 8'h00;
        end
    endtask

    task automatic cycle(input bit wr, input bit rd, input int addr, input logic [7:0] wd,
                         input bit rst_n);
        bit in_r;
        ifa.WrEn = wr; ifa.RdEn = rd; ifa.Address = 4'(addr); ifa.WrData = wd;
        ifb.WrEn = wr; ifb.RdEn = rd; ifb.Address = 4'(addr); ifb.WrData = wd;
        RST = rst_n;
        e++;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                in_r = addr < depth[d];
                if (rd) begin
                    sv[d][e+lat[d]-1] = 1'b1;
                    sd[d][e+lat[d]-1] = in_r ? m[d][addr] : 8'h00;
                end
                se[d][e] = (wr && (!in_r || ro[d][addr])) || (rd && !in_r);
                if (wr && in_r && !ro[d][addr]) m[d][addr] = wd;
            end
        end
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (sv[d][e]) last[d] = sd[d][e];
        end
        check("a_vld",  {31'b0, ifa.RdData_VLD}, {31'b0, sv[0][e]});
        check("a_data", {24'b0, ifa.RdData},     {24'b0, last[0]});
        check("a_err",  {31'b0, ifa.Acc_ERR},    {31'b0, se[0][e]});
        check("a_taps", ifa.REG_TAPS,            {m[0][3], m[0][2], m[0][1], m[0][0]});
        check("b_vld",  {31'b0, ifb.RdData_VLD}, {31'b0, sv[1][e]});
        check("b_data", {24'b0, ifb.RdData},     {24'b0, last[1]});
        check("b_err",  {31'b0, ifb.Acc_ERR},    {31'b0, se[1][e]});
        check("b_taps", ifb.REG_TAPS,            {m[1][3], m[1][2], m[1][1], m[1][0]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2048; k++) begin
                sv[d][k] = 1'b0; se[d][k] = 1'b0; sd[d][k] = 8'h00;
            end
        end

        // Reset image and full read-back
        cycle(0, 0, 0, 8'h00, 0);
        cycle(0, 0, 0, 8'h00, 0);
        check("reset_taps_const", ifa.REG_TAPS, 32'h2081_0000);
        check("reset_vld_const", {31'b0, ifb.RdData_VLD}, 32'h0);
        for (int a = 0; a < 16; a++) cycle(0, 1, a, 8'h00, 1);
        idle(3);

        // Plain write then read
        cycle(1, 0, 5, 8'hA5, 1);
        cycle(0, 1, 5, 8'h00, 1);
        idle(3);
        check("rd5_const", {24'b0, ifb.RdData}, 32'hA5);

        // Protected write: word 3 on A, word 4 on B
        cycle(1, 0, 3, 8'hFF, 1);
        cycle(1, 0, 4, 8'h77, 1);
        cycle(0, 1, 3, 8'h00, 1);
        cycle(0, 1, 4, 8'h00, 1);
        idle(3);

        // Simultaneous read/write returns old data
        cycle(1, 1, 2, 8'h3C, 1);
        cycle(0, 1, 2, 8'h00, 1);
        idle(3);
        check("rbw_const", {24'b0, ifa.RdData}, 32'h3C);

        // Out-of-range accesses (beyond B's depth)
        cycle(0, 1, 14, 8'h00, 1);
        idle(3);
        cycle(1, 0, 13, 8'h5A, 1);
        cycle(1, 1, 12, 8'h11, 1);
        idle(3);

        // Reads in flight when reset hits
        cycle(0, 1, 2, 8'h00, 1);
        cycle(0, 1, 3, 8'h00, 1);
        cycle(0, 1, 5, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 0);
        idle(3);

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                  8'($urandom), ($urandom_range(49, 0) != 0));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
